// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the MEM stage and the UART DMA.
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU_PRI   = 1'b0,
        S_DMA_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_MAX_WAIT = 8;
    localparam int DEF_BURST    = 4;
    localparam int PERIPH_BIT   = 30;
    localparam int WAIT_W       = 8;
    localparam int BURST_W      = 5;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIM)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DataMem arbiter: CPU has priority, a starvation counter forces
// bounded DMA bursts and stalls the pipeline while the DMA owns the port.
//
// state       | meaning
// S_CPU_PRI   | CPU first; DMA only gets idle slots or a forced grant on starvation
// S_DMA_BURST | DMA owns the port until it drops dma_req or the burst limit is hit
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int BURST    = DEF_BURST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST - 1);
    localparam logic               MULTI      = (BURST > 1);

    arb_state_t         state;
    logic               cpu_req;
    logic               starve;
    logic               go_burst;
    logic               leave_burst;
    logic               burst_clr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;

    assign cpu_req = (cpu_rd | cpu_wr) & ~cpu_addr[PERIPH_BIT];
    assign starve  = (wait_cnt == WAIT_MAX);

    sat_counter #(.WIDTH(WAIT_W), .LIMIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_req & ~dma_gnt),
        .clr   (dma_gnt | ~dma_req),
        .count (wait_cnt)
    );

    sat_counter #(.WIDTH(BURST_W), .LIMIT(BURST)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_gnt),
        .clr   (burst_clr),
        .count (burst_cnt)
    );

    // The grant is combinational so the access happens in the request cycle.
    always_comb begin
        dma_gnt     = 1'b0;
        go_burst    = 1'b0;
        leave_burst = 1'b0;
        case (state)
            S_CPU_PRI: begin
                dma_gnt  = dma_req & (~cpu_req | starve);
                go_burst = dma_gnt & cpu_req & starve & MULTI;
            end
            S_DMA_BURST: begin
                dma_gnt     = dma_req;
                leave_burst = ~dma_req | (burst_cnt == BURST_LAST);
            end
            default: ;
        endcase
        burst_clr = (state == S_CPU_PRI) ? ~go_burst : leave_burst;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CPU_PRI;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_wr;
            if (dma_gnt && !dma_wr) begin
                dma_rdata <= mem_rdata;
            end
            case (state)
                S_CPU_PRI:   if (go_burst) state <= S_DMA_BURST;
                S_DMA_BURST: if (leave_burst) state <= S_CPU_PRI;
                default:     state <= S_CPU_PRI;
            endcase
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_gnt) begin
            mem_rd    = ~dma_wr;
            mem_wr    = dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_req) begin
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_req & dma_gnt;
    assign cpu_rdata = dma_gnt ? 32'd0 : mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int MW = 8;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_wr = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem[256];
    logic [31:0] ref_mem[256];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.MAX_WAIT(MW), .BURST(BL)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // DataMem stand-in: combinational read, write on the clock edge.
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) dmem[mem_addr[9:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma_set(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
        dma_req = rq; dma_wr = wr; dma_addr = a; dma_wdata = d;
    endtask

    // Reference model: whose access owns the port, the denial age of the DMA
    // request, and how many grants the current forced burst has used.
    bit          m_burst;
    int          m_bcnt;
    int          m_wait;
    logic [31:0] m_rdata;
    bit          m_rvalid;

    initial begin
        bit          creq, egnt, e_rd, e_wr;
        logic [31:0] e_addr, e_wdata, e_crd;
        int          old_wait;
        m_burst = 0; m_bcnt = 0; m_wait = 0; m_rdata = '0; m_rvalid = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_burst = 0; m_bcnt = 0; m_wait = 0; m_rdata = '0; m_rvalid = 0;
            end
            creq = (cpu_rd || cpu_wr) && !cpu_addr[30];
            egnt = dma_req && (m_burst || !creq || m_wait == MW);
            e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
            if (egnt) begin
                e_rd = !dma_wr; e_wr = dma_wr; e_addr = dma_addr; e_wdata = dma_wdata;
            end else if (creq) begin
                e_rd = cpu_rd; e_wr = cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wdata;
            end
            e_crd = egnt ? 32'd0 : ref_mem[e_addr[9:2]];
            check("dma_gnt",    32'(dma_gnt),    32'(egnt));
            check("cpu_stall",  32'(cpu_stall),  32'(creq && egnt));
            check("mem_rd",     32'(mem_rd),     32'(e_rd));
            check("mem_wr",     32'(mem_wr),     32'(e_wr));
            check("mem_addr",   mem_addr,        e_addr);
            check("mem_wdata",  mem_wdata,       e_wdata);
            check("cpu_rdata",  cpu_rdata,       e_crd);
            check("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
            check("dma_rdata",  dma_rdata,       m_rdata);
            check("wait_cnt",   32'(dut.wait_cnt), 32'(m_wait));
            check("in_burst",   32'(dut.state == S_DMA_BURST), 32'(m_burst));
            @(posedge clk);
            if (reset) begin
                m_rvalid = egnt && !dma_wr;
                if (m_rvalid) m_rdata = ref_mem[dma_addr[9:2]];
                old_wait = m_wait;
                if (egnt || !dma_req) m_wait = 0;
                else if (m_wait < MW) m_wait++;
                if (!m_burst) begin
                    if (egnt && creq && old_wait == MW && BL > 1) begin
                        m_burst = 1; m_bcnt = 1;
                    end
                end else if (!dma_req) begin
                    m_burst = 0; m_bcnt = 0;
                end else begin
                    m_bcnt++;
                    if (m_bcnt == BL) begin
                        m_burst = 0; m_bcnt = 0;
                    end
                end
            end
            if (e_wr) ref_mem[e_addr[9:2]] = e_wdata;
        end
    end

    initial begin
        int  n;
        int  total;
        bit  last_gnt;
        int  op;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        #4;
        check("rst_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_rdata", dma_rdata, 32'd0);
        check("rst_gnt", 32'(dma_gnt), 32'd0);
        tick();
        reset = 1'b1;

        // idle-CPU DMA read
        tick();
        dma_set(1, 0, 32'h40, 0);
        #3;
        check("idle_gnt", 32'(dma_gnt), 32'd1);
        check("idle_stall", 32'(cpu_stall), 32'd0);
        tick();
        dma_set(0, 0, 0, 0);
        #3;
        check("idle_rvalid", 32'(dma_rvalid), 32'd1);
        check("idle_rdata", dma_rdata, 32'hDEADBEEF);
        check("idle_stall2", 32'(cpu_stall), 32'd0);

        // starvation then burst limit
        tick();
        cpu_set(1, 0, 32'h10, 0);
        dma_set(1, 0, 32'h20, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #3;
            n++;
            if (dma_gnt) break;
            tick();
        end
        check("starve_latency", 32'(n), 32'd9);
        check("starve_stall", 32'(cpu_stall), 32'd1);
        total = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            #3;
            if (k == 0) check("burst_state", 32'(dut.state == S_DMA_BURST), 32'd1);
            if (!dma_gnt) break;
            check("burst_stall", 32'(cpu_stall), 32'd1);
            total++;
        end
        check("burst_len", 32'(total), 32'd4);
        check("post_burst_stall", 32'(cpu_stall), 32'd0);
        check("post_burst_mem_rd", 32'(mem_rd), 32'd1);
        check("post_burst_wait", 32'(dut.wait_cnt), 32'd0);
        tick();
        cpu_set(0, 0, 0, 0);
        dma_set(0, 0, 0, 0);

        // write collision under a forced grant
        tick();
        cpu_set(1, 0, 32'h10, 0);
        dma_set(1, 1, 32'h100, 32'h11);
        repeat (8) tick();
        cpu_set(0, 1, 32'h100, 32'h22);
        #3;
        check("coll_gnt", 32'(dma_gnt), 32'd1);
        tick();
        dma_set(0, 0, 0, 0);
        #3;
        check("coll_mem1", dmem[64], 32'h11);
        check("coll_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_set(0, 0, 0, 0);
        #3;
        check("coll_mem2", dmem[64], 32'h22);

        // peripheral bypass
        tick();
        cpu_set(1, 0, 32'h4000_0010, 0);
        dma_set(1, 0, 32'h80, 0);
        #3;
        check("periph_stall", 32'(cpu_stall), 32'd0);
        check("periph_gnt", 32'(dma_gnt), 32'd1);
        check("periph_addr", mem_addr, 32'h80);

        // reset during the second burst grant
        tick();
        cpu_set(1, 0, 32'h10, 0);
        dma_set(1, 0, 32'h84, 0);
        repeat (8) tick();
        tick();
        reset = 1'b0;
        #3;
        check("rst_mid_gnt", 32'(dma_gnt), 32'd0);
        check("rst_mid_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_mid_rdata", dma_rdata, 32'd0);
        tick();
        reset = 1'b1;
        cpu_set(0, 0, 0, 0);
        dma_set(0, 0, 0, 0);
        #3;
        check("rst_rel_state", 32'(dut.state == S_CPU_PRI), 32'd1);
        check("rst_rel_wait", 32'(dut.wait_cnt), 32'd0);

        // randomized traffic; a pending DMA request is held until granted
        last_gnt = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            op = $urandom_range(0, 9);
            cpu_set(op < 4, op >= 4 && op < 7,
                    {1'b0, ($urandom_range(0, 4) == 0), 20'd0, 8'($urandom), 2'b00}, $urandom);
            if (!(dma_req && !last_gnt)) begin
                dma_set($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        {22'd0, 8'($urandom), 2'b00}, $urandom);
            end
            #3;
            last_gnt = dma_gnt;
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
